// File: rtl/dmem_pkg.sv
// Shared types and address checking for the data-memory responder.
// Also intended for reuse by an instruction-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WORD_BYTES = 4;

  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return {2'b00, addr[31:2]};
  endfunction

  // Misaligned or beyond the last stored word.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Word storage: asynchronous clear, byte-masked synchronous write,
// combinational read port.
module dmem_responder_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [31:0]           wdata,
  input  logic [WORD_BYTES-1:0] wbe,
  input  logic [AW-1:0]         raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (wbe[b]) begin
          mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder with configurable access latency, one transaction
// outstanding. Optional byte-lane stores enabled by DMEM_RESP_BYTE_EN_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_RESP_BYTE_EN_EN
  input  logic [3:0]  req_be,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        access;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_be;
  logic        acc_err;
  logic [AW-1:0] acc_idx;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [3:0]  in_be;

`ifdef DMEM_RESP_BYTE_EN_EN
  assign in_be = req_be;
`else
  assign in_be = 4'hF;
`endif

  // With LATENCY=1 the access happens on the accept edge itself, so the
  // live request is used instead of the (not yet loaded) latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = in_be;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
    acc_err = addr_err(acc_addr, DEPTH);
    acc_idx = AW'(word_index(acc_addr));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    access      = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          be_d        = in_be;
          cnt_d       = CNT_INIT;
          req_ready_d = 1'b0;
          if (LATENCY > 1) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            access  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (access) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_we || acc_err) ? 32'h0 : mem_rdata;
    end
  end

  assign mem_we = access && acc_we && !acc_err;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  dmem_responder_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk   (clk),
    .rstn  (rstn),
    .we    (mem_we),
    .waddr (acc_idx),
    .wdata (acc_wdata),
    .wbe   (acc_be),
    .raddr (acc_idx),
    .rdata (mem_rdata)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic checked
// against a word-array model of the memory.
module tb_dmem_responder;

  localparam int DEPTH = 32;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
`ifdef DMEM_RESP_BYTE_EN_EN
  logic [3:0]  req_be = 4'hF;
`endif
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMEM_RESP_BYTE_EN_EN
    .req_be    (req_be),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  // Memory semantics straight from the address rules: word index = addr/4.
  task automatic ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be_in, output logic [31:0] rdata, output logic err);
    logic [3:0] be;
    int idx;
    be = be_in;
`ifndef DMEM_RESP_BYTE_EN_EN
    be = 4'hF;
`endif
    err = ((addr % 4) != 0) || ((addr / 4) >= DEPTH);
    rdata = '0;
    if (!err) begin
      idx = int'(addr / 4);
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        rdata = model_mem[idx];
      end
    end
  endtask

  // Starts at a negedge with the DUT idle; returns at a negedge after the handshake.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int stall, input bit pend, input string tag);
    logic [31:0] er;
    logic ee;
    int lat;
    chk({tag, " ready_at_start"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
`ifdef DMEM_RESP_BYTE_EN_EN
    req_be    = be;
`endif
    @(posedge clk);
    #1;
    ref_access(we, addr, wdata, be, er, ee);
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 50);
    chk({tag, " latency"}, 32'(lat), 32'(LAT));
    chk({tag, " rdata"}, rsp_rdata, er);
    chk({tag, " err"}, 32'(rsp_err), 32'(ee));
    chk({tag, " ready_in_resp"}, 32'(req_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      if (pend) begin
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = $urandom;
      end
      @(negedge clk);
      chk({tag, " stall_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " stall_rdata"}, rsp_rdata, er);
      chk({tag, " stall_err"}, 32'(rsp_err), 32'(ee));
      chk({tag, " stall_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, " valid_after_hs"}, 32'(rsp_valid), 32'd0);
    $display("txn %s we=%0d addr=%h wdata=%h be=%h -> rdata=%h err=%0d lat=%0d",
             tag, we, addr, wdata, be, er, ee, lat);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  be;
    int kind;

    // Reset with a request pending: nothing may be accepted.
    rstn = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 32'h8;
    req_wdata = 32'h55AA55AA;
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    req_valid = 1'b0;
    rstn = 1'b1;
    model_clear();
    @(negedge clk);
    chk("rst release ready", 32'(req_ready), 32'd1);
    chk("rst release valid", 32'(rsp_valid), 32'd0);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, "st10");
    txn(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, "ld10");
    txn(1'b0, 32'h8, 32'h0, 4'hF, 0, 1'b0, "ld8_rstwrite");

    // Backpressure with a request waiting; next txn starts right after the handshake.
    txn(1'b0, 32'h10, 32'h0, 4'hF, 5, 1'b1, "bp");
    txn(1'b1, 32'h14, 32'h0BADF00D, 4'hF, 0, 1'b0, "pend_st14");
    txn(1'b0, 32'h14, 32'h0, 4'hF, 0, 1'b0, "ld14");

    txn(1'b0, 32'h13, 32'h0, 4'hF, 0, 1'b0, "ld_misal");
    txn(1'b1, 32'(DEPTH * 4), 32'hCAFEF00D, 4'hF, 0, 1'b0, "st_oor");
    txn(1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0, "ld0_after_oor");
    txn(1'b1, 32'h12, 32'h12345678, 4'hF, 0, 1'b0, "st_misal");
    txn(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, "ld10_after_misal");
    txn(1'b0, 32'(DEPTH * 4 - 4), 32'h0, 4'hF, 0, 1'b0, "ld_last");

    // Reset while the store is in flight drops it and clears memory.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h4;
    req_wdata = 32'h1234;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst req_ready", 32'(req_ready), 32'd0);
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    txn(1'b0, 32'h4, 32'h0, 4'hF, 0, 1'b0, "ld4_after_midrst");
    txn(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, "ld10_after_midrst");

`ifdef DMEM_RESP_BYTE_EN_EN
    txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 0, 1'b0, "be_full");
    txn(1'b1, 32'h20, 32'h00000000, 4'b0101, 0, 1'b0, "be_0101");
    txn(1'b0, 32'h20, 32'h0, 4'b0000, 0, 1'b0, "be_ld20");
    chk("be_model", model_mem[8], 32'hFF00FF00);
    txn(1'b1, 32'h20, 32'h11111111, 4'b0000, 0, 1'b0, "be_none");
    txn(1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, "be_ld20_again");
`endif

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 7)      a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      else if (kind < 9) a = 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'd1;
      else               a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255)) * 4;
      be = 4'($urandom_range(0, 15));
      txn(1'($urandom_range(0, 1)), a, $urandom, be, int'($urandom_range(0, 3)), 1'b0, "rnd");
    end

    for (int w = 0; w < 8; w++) begin
      txn(1'b0, 32'(w * 4), 32'h0, 4'hF, 0, 1'b0, "readback");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
